// File: rtl/shift_right_sequencer.sv
// rtl/shift_right_sequencer.sv - bit-serial sequencer driving a shared right shifter
// Optional single-pass mode (full amount in one shifter pass): SHIFT_SEQ_SINGLE_PASS_EN
module shift_right_sequencer #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] aDesplace,
  input  logic         sign,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] sh_a,
  output logic [N-1:0] sh_aDesplace,
  output logic         sh_sign,
  input  logic [N-1:0] sh_result
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [N-1:0] AMT_MAX = N[N-1:0];

  state_t       state, state_nxt;
  logic [N-1:0] acc, acc_nxt;
  logic [N-1:0] cnt, cnt_nxt;
  logic         sign_q, sign_nxt;
  logic [N-1:0] amt_clamped;

  // Amounts past the width all saturate to a full shift-out.
  assign amt_clamped = (aDesplace >= AMT_MAX) ? AMT_MAX : aDesplace;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    sign_nxt  = sign_q;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = a;
          sign_nxt  = sign;
          cnt_nxt   = amt_clamped;
          state_nxt = (amt_clamped == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_nxt = sh_result;
`ifdef SHIFT_SEQ_SINGLE_PASS_EN
        cnt_nxt   = '0;
        state_nxt = DONE;
`else
        cnt_nxt = cnt - N'(1);
        if (cnt == N'(1)) begin
          state_nxt = DONE;
        end
`endif
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      sign_q <= sign_nxt;
      // Capture the value being written to acc on the edge that enters DONE.
      if (state_nxt == DONE) begin
        result <= acc_nxt;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign sh_a    = acc;
  assign sh_sign = sign_q;
`ifdef SHIFT_SEQ_SINGLE_PASS_EN
  assign sh_aDesplace = cnt;
`else
  assign sh_aDesplace = N'(1);
`endif

endmodule

// File: tb/tb_shift_right_sequencer.sv
// tb/tb_shift_right_sequencer.sv - scoreboard bench for shift_right_sequencer
module tb_shift_right_sequencer;

  localparam int N = 5;

  typedef struct {
    logic [N-1:0] res;
    int           edges;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] aDesplace = '0;
  logic         sign = 1'b0;
  logic         busy, done;
  logic [N-1:0] result, sh_a, sh_aDesplace, sh_result;
  logic         sh_sign;

  int total = 0;
  int bad = 0;
  exp_t         sbq[$];
  logic [N-1:0] trace[$];

  always #5 clk = ~clk;

  // Combinational shifter the sequencer is expected to drive.
  always_comb begin
    if (sh_sign) sh_result = N'($signed(sh_a) >>> sh_aDesplace);
    else         sh_result = sh_a >> sh_aDesplace;
  end

  shift_right_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .aDesplace(aDesplace), .sign(sign),
    .busy(busy), .done(done), .result(result), .sh_a(sh_a),
    .sh_aDesplace(sh_aDesplace), .sh_sign(sh_sign), .sh_result(sh_result)
  );

  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] av, input logic [N-1:0] amt,
                                             input logic sg);
    logic [N-1:0] r;
    int k;
    k = (int'(amt) >= N) ? N : int'(amt);
    r = av;
    for (int i = 0; i < k; i++) r = {sg ? r[N-1] : 1'b0, r[N-1:1]};
    return r;
  endfunction

  function automatic int exp_edges(input logic [N-1:0] amt);
    int k;
    k = (int'(amt) >= N) ? N : int'(amt);
`ifdef SHIFT_SEQ_SINGLE_PASS_EN
    return (k == 0) ? 1 : 2;
`else
    return k + 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [N-1:0] av, input logic [N-1:0] amt, input logic sg);
    exp_t e;
    a = av; aDesplace = amt; sign = sg; start = 1'b1;
    e.res = ref_shift(av, amt, sg);
    e.edges = exp_edges(amt);
    sbq.push_back(e);
  endtask

  // Caller is at a negedge having already counted edges0 edges since start was sampled.
  task automatic wait_done(input string tag, input int edges0);
    int edges;
    exp_t e;
    edges = edges0;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      trace.push_back(sh_a);
    end
    e = sbq.pop_front();
    check({tag, " latency"}, edges, e.edges);
    check({tag, " result"}, result, e.res);
    @(negedge clk);
    check({tag, " done pulse"}, done, 1'b0);
    check({tag, " busy idle"}, busy, 1'b0);
  endtask

  task automatic run_cmd(input string tag, input logic [N-1:0] av, input logic [N-1:0] amt,
                         input logic sg);
    @(negedge clk);
    push_cmd(av, amt, sg);
    trace.delete();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    trace.push_back(sh_a);
    check({tag, " busy"}, busy, 1'b1);
    wait_done(tag, 1);
  endtask

  initial begin
    int dones;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, '0);
    rst = 1'b0;

    run_cmd("t1", 5'b01011, 5'b00001, 1'b0);
    check("t1 const", result, 5'b00101);

    run_cmd("t2", 5'b10110, 5'b00011, 1'b1);
    check("t2 const", result, 5'b11110);
`ifndef SHIFT_SEQ_SINGLE_PASS_EN
    check("t2 partial1", trace[1], 5'b11011);
    check("t2 partial2", trace[2], 5'b11101);
    check("t2 partial3", trace[3], 5'b11110);
`endif

    run_cmd("t3", 5'b10110, 5'b00000, 1'b1);
    check("t3 const", result, 5'b10110);

    run_cmd("t4 log", 5'b11111, 5'b00111, 1'b0);
    check("t4 log const", result, 5'b00000);
    run_cmd("t4 ari", 5'b11111, 5'b00111, 1'b1);
    check("t4 ari const", result, 5'b11111);
    run_cmd("amt5 ari", 5'b10000, 5'b00101, 1'b1);
    run_cmd("amt4 log", 5'b11010, 5'b00100, 1'b0);
    run_cmd("amt31 ari", 5'b01101, 5'b11111, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_cmd("rand", 5'($urandom), 5'($urandom_range(0, 6)), 1'($urandom));
    end

    // Start while busy is dropped, not queued.
    @(negedge clk);
    push_cmd(5'b10110, 5'b00011, 1'b1);
    @(posedge clk);
    @(negedge clk);
    a = 5'b01011; aDesplace = 5'b00001; sign = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("t5", 2);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("t5 no second done", dones, 0);

    // Mid-command reset aborts without a done pulse.
    @(negedge clk);
    a = 5'b10110; aDesplace = 5'b00100; sign = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
`ifndef SHIFT_SEQ_SINGLE_PASS_EN
    repeat (2) @(posedge clk);
    @(negedge clk);
`endif
    check("t6 busy before rst", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t6 busy", busy, 1'b0);
    check("t6 done", done, 1'b0);
    check("t6 result", result, '0);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("t6 no done", dones, 0);
    run_cmd("t6 after", 5'b01011, 5'b00001, 1'b0);
    check("t6 after const", result, 5'b00101);

    check("scoreboard empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
